// File: rtl/hilo_mdu_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package hilo_mdu_pkg;

    localparam int unsigned MDU_WIDTH     = 32;
    localparam int unsigned MDU_DIV_STEPS = 32;

    // HI/LO write intent from decode; 3'b111 is not named and falls to NONE.
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DIV_FIX = 2'd2
    } mdu_state_e;

    // Quotient forced on divide by zero; the remainder naturally equals the dividend.
    localparam logic [MDU_WIDTH-1:0] DIV0_QUO = '1;

    // True for the two opcodes that launch the iterative divider.
    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/hilo_mdu_if.sv
// Execute-stage request / HI-LO result bundle between the pipeline and the MDU.
interface hilo_mdu_if #(
    parameter int unsigned W = 32
);
    logic         start;
    logic [2:0]   mdop;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         flush;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;
    logic         busy;
    logic         done;

    modport master (
        output start, mdop, srca, srcb, flush,
        input  hi_o, lo_o, busy, done
    );

    modport slave (
        input  start, mdop, srca, srcb, flush,
        output hi_o, lo_o, busy, done
    );
endinterface

// File: rtl/hilo_mdu_div_core.sv
// Unsigned restoring divider, one quotient bit per step.
module hilo_mdu_div_core #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DIV_STEPS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             last_step
);
    localparam int unsigned CNT_W = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   rem_sh;
    logic             fits;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign rem_sh    = {rem, quo[WIDTH-1]};
    assign fits      = rem_sh >= {1'b0, dsr};
    assign last_step = (cnt == CNT_W'(DIV_STEPS - 1));

    // {rem,quo} shift-subtract register; quo doubles as the dividend shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo <= '0;
            rem <= '0;
            dsr <= '0;
            cnt <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
            dsr <= divisor;
            cnt <= '0;
        end else if (step) begin
            rem <= fits ? WIDTH'(rem_sh - {1'b0, dsr}) : rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], fits};
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hilo_mdu.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
module hilo_mdu
    import hilo_mdu_pkg::*;
#(
    parameter int unsigned WIDTH     = MDU_WIDTH,
    parameter int unsigned DIV_STEPS = MDU_DIV_STEPS
) (
    input  logic       clk,
    input  logic       rst,
    hilo_mdu_if.slave  bus
);
    localparam int unsigned DW = 2 * WIDTH;

    mdu_state_e       state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             q_neg;
    logic             r_neg;
    logic             div0;

    logic             issue_ok;
    logic             is_div;
    logic             is_sdiv;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [DW-1:0]    prod_s;
    logic [DW-1:0]    prod_u;
    logic             load;
    logic             step;
    logic             last_step;

    // Issue qualification: only an unflushed start in IDLE does anything.
    assign issue_ok = bus.start && !bus.flush && (state == IDLE);
    assign is_div   = is_div_op(bus.mdop);
    assign is_sdiv  = (bus.mdop == MD_DIV);
    assign a_neg    = is_sdiv && bus.srca[WIDTH-1];
    assign b_neg    = is_sdiv && bus.srcb[WIDTH-1];
    assign abs_a    = a_neg ? WIDTH'(-bus.srca) : bus.srca;
    assign abs_b    = b_neg ? WIDTH'(-bus.srcb) : bus.srcb;

    // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
    assign prod_s = {{WIDTH{bus.srca[WIDTH-1]}}, bus.srca} * {{WIDTH{bus.srcb[WIDTH-1]}}, bus.srcb};
    assign prod_u = {{WIDTH{1'b0}}, bus.srca} * {{WIDTH{1'b0}}, bus.srcb};

    assign load  = issue_ok && is_div;
    assign step  = (state == DIV_RUN) && !bus.flush;
    assign q_fix = q_neg ? WIDTH'(-quo) : quo;
    assign r_fix = r_neg ? WIDTH'(-rem) : rem;

    // Stall must cover the issue cycle, hence the combinational launch term.
    assign bus.busy = (state != IDLE) || load;
    assign bus.done = (state == DIV_FIX) && !bus.flush && !rst;
    assign bus.hi_o = hi;
    assign bus.lo_o = lo;

    hilo_mdu_div_core #(
        .WIDTH     (WIDTH),
        .DIV_STEPS (DIV_STEPS)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .quo       (quo),
        .rem       (rem),
        .last_step (last_step)
    );

    // Control FSM plus HI/LO writes; flush or reset abandon a divide without commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            div0  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue_ok) begin
                        case (bus.mdop)
                            MD_MULT:  {hi, lo} <= prod_s;
                            MD_MULTU: {hi, lo} <= prod_u;
                            MD_MTHI:  hi <= bus.srca;
                            MD_MTLO:  lo <= bus.srca;
                            MD_DIV, MD_DIVU: begin
                                q_neg <= a_neg ^ b_neg;
                                r_neg <= a_neg;
                                div0  <= (bus.srcb == '0);
                                state <= DIV_RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                DIV_RUN: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else if (last_step) begin
                        state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    state <= IDLE;
                    if (!bus.flush) begin
                        lo <= div0 ? WIDTH'(DIV0_QUO) : q_fix;
                        hi <= r_fix;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: scoreboard of expected {hi,lo} per instruction.
module tb_hilo_mdu;
    import hilo_mdu_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hl_t;

    typedef struct packed {
        logic [2:0]  op;
        logic        fl;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    hl_t  scb[$];
    hl_t  mreg = '0;

    always #5 clk = ~clk;

    hilo_mdu_if #(.W(32)) bus();

    hilo_mdu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Architectural reference for one HI/LO-writing instruction.
    function automatic hl_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic fl, input hl_t cur);
        hl_t    r;
        longint sa;
        longint sb;
        longint q;
        longint rm;
        r  = cur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (!fl) begin
            case (op)
                3'd1: r = sa * sb;
                3'd2: r = {32'd0, a} * {32'd0, b};
                3'd3: begin
                    if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                    else begin
                        q  = sa / sb;
                        rm = sa % sb;
                        r  = {32'(rm), 32'(q)};
                    end
                end
                3'd4: begin
                    if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                    else r = {a % b, a / b};
                end
                3'd5: r.hi = a;
                3'd6: r.lo = a;
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic drive_idle();
        bus.start = 1'b0;
        bus.mdop  = 3'd0;
        bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        bus.srca = '0;
        bus.srcb = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.hi_o, bus.lo_o, bus.busy, bus.done} !== 66'd0) begin
            n_bad++;
            $display("FAIL reset: got hi=%h lo=%h busy=%b done=%b want all zero",
                     bus.hi_o, bus.lo_o, bus.busy, bus.done);
        end
        mreg = '0;
    endtask

    task automatic test_mt();
        op_t t[2];
        hl_t e;
        t[0] = '{op: 3'd5, fl: 1'b0, a: 32'h1234_5678, b: 32'h0};
        t[1] = '{op: 3'd6, fl: 1'b0, a: 32'h9ABC_DEF0, b: 32'h0};
        for (int i = 0; i <= 2; i++) begin
            @(negedge clk);
            if (i < 2) begin
                bus.start = 1'b1; bus.mdop = t[i].op; bus.srca = t[i].a; bus.srcb = t[i].b; bus.flush = t[i].fl;
                mreg = model(t[i].op, t[i].a, t[i].b, t[i].fl, mreg);
                scb.push_back(mreg);
            end else drive_idle();
            #1;
            n_cmp++;
            if (bus.busy !== 1'b0) begin
                n_bad++; $display("FAIL mt_busy[%0d]: got %b want 0", i, bus.busy);
            end
            if (i > 0) begin
                e = scb.pop_front();
                n_cmp++;
                if ({bus.hi_o, bus.lo_o} !== e) begin
                    n_bad++; $display("FAIL mt_hilo[%0d]: got %h_%h want %h_%h", i, bus.hi_o, bus.lo_o, e.hi, e.lo);
                end
            end
        end
    endtask

    task automatic test_mult();
        op_t t[5];
        hl_t e;
        t[0] = '{op: 3'd1, fl: 1'b0, a: 32'hFFFF_FFFE, b: 32'h0000_0003};
        t[1] = '{op: 3'd2, fl: 1'b0, a: 32'hFFFF_FFFE, b: 32'h0000_0003};
        t[2] = '{op: 3'd1, fl: 1'b1, a: 32'h0000_1234, b: 32'h0000_5678};
        t[3] = '{op: 3'd7, fl: 1'b0, a: 32'hDEAD_BEEF, b: 32'h0000_0002};
        t[4] = '{op: 3'd1, fl: 1'b0, a: 32'h8000_0000, b: 32'h8000_0000};
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i < 5) begin
                bus.start = 1'b1; bus.mdop = t[i].op; bus.srca = t[i].a; bus.srcb = t[i].b; bus.flush = t[i].fl;
                mreg = model(t[i].op, t[i].a, t[i].b, t[i].fl, mreg);
                scb.push_back(mreg);
            end else drive_idle();
            #1;
            n_cmp++;
            if (bus.busy !== 1'b0) begin
                n_bad++; $display("FAIL mult_busy[%0d]: got %b want 0", i, bus.busy);
            end
            if (i > 0) begin
                e = scb.pop_front();
                n_cmp++;
                if ({bus.hi_o, bus.lo_o} !== e) begin
                    n_bad++; $display("FAIL mult_hilo[%0d]: got %h_%h want %h_%h", i, bus.hi_o, bus.lo_o, e.hi, e.lo);
                end
            end
        end
    endtask

    // Issue a divide, hold the stalled start with altered data, release after done.
    task automatic test_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        hl_t e;
        @(negedge clk);
        bus.start = 1'b1; bus.mdop = op; bus.srca = a; bus.srcb = b; bus.flush = 1'b0;
        mreg = model(op, a, b, 1'b0, mreg);
        scb.push_back(mreg);
        #1;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_bad++; $display("FAIL div_issue: got busy=%b done=%b want busy=1 done=0", bus.busy, bus.done);
        end
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (k <= 33) bus.srca = ~a;
            #1;
            n_cmp++;
            if (bus.busy !== (k <= 33) || bus.done !== (k == 33)) begin
                n_bad++;
                $display("FAIL div_cycle[N+%0d]: got busy=%b done=%b want busy=%b done=%b",
                         k, bus.busy, bus.done, (k <= 33), (k == 33));
            end
            if (k == 33) drive_idle();
            if (k == 34) e = scb.pop_front();
            if (k >= 34) begin
                n_cmp++;
                if ({bus.hi_o, bus.lo_o} !== e) begin
                    n_bad++; $display("FAIL div_hilo[op%0d N+%0d]: got %h_%h want %h_%h",
                                      op, k, bus.hi_o, bus.lo_o, e.hi, e.lo);
                end
            end
        end
    endtask

    task automatic test_flush();
        hl_t e;
        @(negedge clk);
        bus.start = 1'b1; bus.mdop = 3'd4; bus.srca = 32'd1000; bus.srcb = 32'd7; bus.flush = 1'b0;
        scb.push_back(mreg);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.flush = (k == 10);
            #1;
            n_cmp++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                n_bad++; $display("FAIL flush_run[N+%0d]: got busy=%b done=%b want 1/0", k, bus.busy, bus.done);
            end
        end
        // Cycle N+11: divide abandoned; also try a start that arrives with flush.
        @(negedge clk);
        bus.start = 1'b1; bus.mdop = 3'd3; bus.srca = 32'd50; bus.srcb = 32'd5; bus.flush = 1'b1;
        #1;
        e = scb.pop_front();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || {bus.hi_o, bus.lo_o} !== e) begin
            n_bad++; $display("FAIL flush_idle: got busy=%b done=%b hilo=%h_%h want 0/0 %h_%h",
                              bus.busy, bus.done, bus.hi_o, bus.lo_o, e.hi, e.lo);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_idle();
            #1;
            n_cmp++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                n_bad++; $display("FAIL flush_nolaunch[%0d]: got busy=%b done=%b want 0/0", k, bus.busy, bus.done);
            end
        end
        @(negedge clk);
        bus.start = 1'b1; bus.mdop = 3'd6; bus.srca = 32'd5; bus.flush = 1'b0;
        mreg = model(3'd6, 32'd5, 32'd0, 1'b0, mreg);
        scb.push_back(mreg);
        @(negedge clk);
        drive_idle();
        #1;
        e = scb.pop_front();
        n_cmp++;
        if ({bus.hi_o, bus.lo_o} !== e) begin
            n_bad++; $display("FAIL flush_mtlo: got %h_%h want %h_%h", bus.hi_o, bus.lo_o, e.hi, e.lo);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.start = 1'b1; bus.mdop = 3'd3; bus.srca = 32'hFFFF_FF9C; bus.srcb = 32'd3; bus.flush = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.srca = 32'h0000_0777;
            rst = (k == 20);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        #1;
        n_cmp++;
        if ({bus.hi_o, bus.lo_o, bus.busy, bus.done} !== 66'd0) begin
            n_bad++; $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b want all zero",
                              bus.hi_o, bus.lo_o, bus.busy, bus.done);
        end
        mreg = '0;
    endtask

    task automatic test_back_to_back();
        op_t t[4];
        hl_t e;
        t[0] = '{op: 3'd5, fl: 1'b0, a: 32'hCAFE_F00D, b: 32'h0};
        t[1] = '{op: 3'd2, fl: 1'b0, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF};
        t[2] = '{op: 3'd6, fl: 1'b0, a: 32'h0BAD_0BAD, b: 32'h0};
        t[3] = '{op: 3'd1, fl: 1'b0, a: 32'h7FFF_FFFF, b: 32'hFFFF_FFFF};
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) begin
                bus.start = 1'b1; bus.mdop = t[i].op; bus.srca = t[i].a; bus.srcb = t[i].b; bus.flush = t[i].fl;
                mreg = model(t[i].op, t[i].a, t[i].b, t[i].fl, mreg);
                scb.push_back(mreg);
            end else drive_idle();
            #1;
            if (i > 0) begin
                e = scb.pop_front();
                n_cmp++;
                if ({bus.hi_o, bus.lo_o} !== e || bus.busy !== 1'b0) begin
                    n_bad++; $display("FAIL b2b[%0d]: got %h_%h busy=%b want %h_%h busy=0",
                                      i, bus.hi_o, bus.lo_o, bus.busy, e.hi, e.lo);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mt();
        test_mult();
        test_div(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        test_div(3'd4, 32'd100, 32'd0);
        test_div(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        test_div(3'd3, 32'hFFFF_FFF9, 32'd0);
        test_flush();
        test_reset_mid();
        test_div(3'd4, 32'd1000, 32'd7);
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
